// File: rtl/uart_tx.sv
// ============================================================================
// Module   : uart_tx
// Function : Byte-wide 8N1 UART transmitter, LSB first, valid/ready input.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx #(
  parameter int clk_freq = 12000000,
  parameter int baud     = 115200
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);

  localparam int DIV   = clk_freq / baud;
  localparam int CNT_W = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  if (DIV < 2) begin : g_div_check
    $error("uart_tx: clk_freq / baud must be at least 2");
  end

  logic [1:0]       r_state, w_state_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx, w_cnt_inc;
  logic [2:0]       r_bidx, w_bidx_nx;
  logic [7:0]       r_shreg, w_shreg_nx;
  logic             w_bit_end;
  logic             w_tx_nx, w_ready_nx;

  assign w_bit_end = (r_cnt == CNT_MAX);
  assign w_cnt_inc = w_bit_end ? '0 : r_cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bidx  <= '0;
      r_shreg <= '0;
      tx      <= 1'b1;
      ready   <= 1'b1;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_bidx  <= w_bidx_nx;
      r_shreg <= w_shreg_nx;
      tx      <= w_tx_nx;
      ready   <= w_ready_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_bidx_nx  = r_bidx;
    w_shreg_nx = r_shreg;
    case (r_state)
      S_IDLE: begin
        if (valid) begin
          w_shreg_nx = data;
          w_cnt_nx   = '0;
          w_bidx_nx  = '0;
          w_state_nx = S_START;
        end
      end
      S_START: begin
        w_cnt_nx = w_cnt_inc;
        if (w_bit_end) w_state_nx = S_DATA;
      end
      S_DATA: begin
        w_cnt_nx = w_cnt_inc;
        if (w_bit_end) begin
          w_shreg_nx = {1'b0, r_shreg[7:1]};
          if (r_bidx == 3'd7) w_state_nx = S_STOP;
          else                w_bidx_nx  = r_bidx + 3'd1;
        end
      end
      default: begin
        w_cnt_nx = w_cnt_inc;
        if (w_bit_end) w_state_nx = S_IDLE;
      end
    endcase
  end

  // Outputs are computed from the next state so tx/ready are registered yet
  // change on the same edge as the state they describe.
  always_comb begin
    w_tx_nx    = 1'b1;
    w_ready_nx = (w_state_nx == S_IDLE);
    case (w_state_nx)
      S_START: w_tx_nx = 1'b0;
      S_DATA:  w_tx_nx = w_shreg_nx[0];
      default: w_tx_nx = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: doc/uart_tx.md
# uart_tx

Byte-wide UART transmitter, 8N1, LSB first, for the board-side return path of the VGA image link. It accepts a byte on a valid/ready handshake, serialises it on `tx` at the configured baud rate, and returns to idle. Bit timing comes from an internal divider with the same `clk_freq`/`baud` parameterisation as `baudgen`. The divider is restarted on every accepted byte so bit edges align to the start of the frame.

## Interface

- `clk_freq`, default 12000000: system clock frequency in Hz.
- `baud`, default 115200: line rate in bit/s.
- Derived `DIV = clk_freq / baud`, using integer division (104 at defaults). `DIV` must be ≥ 2; elaboration fails otherwise. The counter width is `$clog2(DIV)`.

- `clk`  input  1  system clock; all state updates on the rising edge.
- `rstn`  input  1  asynchronous, active-low reset.
- `data`  input  8  byte to send; sampled only on the accept edge.
- `valid`  input  1  `data` is offered.
- `ready`  output  1  transmitter idle and able to accept; registered.
- `tx`  output  1  serial line, idle high; registered.

## Operation

- States: IDLE, START, DATA, STOP. Internal registers:
  - 8-bit shift register
  - 3-bit bit index
  - bit-period counter `cnt`, range 0..DIV-1
- **Reset** (rstn low, takes effect immediately, independent of `clk`): state=IDLE, `tx`=1, `ready`=1, `cnt`=0, bit index 0, shift register 0.
- **IDLE**: `tx`=1, `ready`=1. On an edge with `valid`=1, the byte is accepted:
  - latch `data` into the shift register;
  - `cnt`←0, bit index←0;
  - state←START, `ready`←0.
- **START**: `tx`=0 for DIV cycles. When `cnt`=DIV-1: `cnt`←0, state←DATA.
- **DATA**: `tx` = shift register bit 0 for DIV cycles per bit. When `cnt`=DIV-1:
  - shift right;
  - if bit index = 7, state←STOP; otherwise increment the bit index.
- **STOP**: `tx`=1 for DIV cycles. When `cnt`=DIV-1: state←IDLE, `ready`←1.
- `cnt` increments every cycle outside IDLE and wraps to 0 at DIV-1. It never exceeds DIV-1.
- `valid` outside IDLE is ignored. No byte is queued, and `data` changes have no effect on a frame in progress.

## Timing

- Accept edge = the rising edge where `ready`=1 and `valid`=1.
- The start bit appears on `tx` in the cycle after the accept edge (1-cycle latency).
- `tx` bit k (k=0 start, 1..8 data bits d0..d7, 9 stop) is driven for cycles `[1 + k*DIV, (k+1)*DIV]` after the accept edge.
- `ready` is low for exactly 10*DIV cycles and returns high at cycle 10*DIV+1.
- Back-to-back bytes: with `valid` held high, the next accept edge is the first edge at which `ready`=1. The start-bit-to-start-bit period is therefore 10*DIV+1 cycles, giving one idle-high cycle between frames.
- Reset mid-frame: the frame is aborted immediately, `tx` goes high at once, and the partial byte is discarded. The first accept after `rstn` rises produces a complete, correctly timed frame.
- `ready` and `tx` are glitch-free register outputs. No combinational path exists from `valid` or `data` to any output.

## Test plan

- **Reset and idle.** `clk_freq`=10, `baud`=1 (DIV=10). Hold `rstn`=0 for 5 cycles, release, keep `valid`=0 for 50 cycles → `tx`=1 and `ready`=1 throughout.
- **Single byte 0x55** (DIV=10). Pulse `valid` for 1 cycle with `data`=0x55 → `tx` shows 0,1,0,1,0,1,0,1,0,1, each level held 10 cycles. `ready`=0 for 100 cycles and is high again at cycle 101 after the accept edge.
- **Back-to-back** (DIV=10). Hold `valid`=1 and change `data` from 0x00 to 0xFF on the first accept edge → frame 1 has its start bit and d0..d7 all low, then stop high. Frame 2 has start low, 8 high data bits, stop high. The start bits are 101 cycles apart with exactly 1 idle-high cycle between frames.
- **Ignored offers** (DIV=10). Send 0xA3, then pulse `valid` with `data`=0x3C during its bit 4 → the line carries only 0xA3 (d0..d7 = 1,1,0,0,0,1,0,1). No second frame follows, and `ready` timing is unchanged.
- **Asynchronous reset mid-frame** (DIV=10). Assert `rstn`=0 between clock edges during d3 of 0xF0 → `tx`=1 and `ready`=1 before the next edge. After release, sending 0x81 produces a correct 100-cycle frame.
- **Default parameters** (DIV=104). Send 0x01 → the start bit lasts 104 cycles, d0 is high for 104 cycles, and the frame is 1040 cycles long (`ready` low for 1040 cycles).
